// File: rtl/vx_dcr_bank_pkg.sv
// Shared types and constants for the double-buffered DCR bank.
// Imported by the bank and its commit controller.
package vx_dcr_bank_pkg;

  localparam int          DCR_BANK_SIZE = 4;
  localparam logic [11:0] DCR_BANK_BASE = 12'h001;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    APPLY
  } dcr_commit_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vx_dcr_bank_commit_ctrl.sv
// Commit sequencer: holds a commit request until the consumer is idle,
// then raises apply for one cycle and commit_done the cycle after.
module vx_dcr_bank_commit_ctrl
  import vx_dcr_bank_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic commit,
  input  logic busy,
  output logic apply,
  output logic commit_done
);

  dcr_commit_state_e state;
  dcr_commit_state_e state_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      commit_done <= 1'b0;
    end else begin
      state       <= state_next;
      commit_done <= apply;
    end
  end

  // Requests seen in WAIT or APPLY fold into the pending transfer.
  always_comb begin
    state_next = state;
    apply      = 1'b0;
    unique case (state)
      IDLE: begin
        if (commit) begin
          state_next = busy ? WAIT : APPLY;
        end
      end
      WAIT: begin
        if (!busy) begin
          state_next = APPLY;
        end
      end
      APPLY: begin
        apply      = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/vx_dcr_bank.sv
// Double-buffered DCR bank: host writes land in shadow, a commit copies
// shadow to active once the consumer is idle.
module vx_dcr_bank
  import vx_dcr_bank_pkg::*;
#(
  parameter int                    NUM_REGS    = DCR_BANK_SIZE,
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 12,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(DCR_BANK_BASE),
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         dcr_wr_valid,
  input  logic [ADDR_WIDTH-1:0]        dcr_wr_addr,
  input  logic [DATA_WIDTH-1:0]        dcr_wr_data,
  input  logic                         dcr_rd_valid,
  input  logic [ADDR_WIDTH-1:0]        dcr_rd_addr,
  output logic                         dcr_rd_rsp_valid,
  output logic [DATA_WIDTH-1:0]        dcr_rd_rsp_data,
  input  logic                         commit,
  input  logic                         busy,
  output logic                         commit_done,
  output logic                         dirty,
  output logic                         addr_err,
  output logic [NUM_REGS*DATA_WIDTH-1:0] active_dcrs
);

  localparam int IW = idx_width(NUM_REGS);
  localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH+1)'(NUM_REGS);

  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [DATA_WIDTH-1:0] active [NUM_REGS];

  logic [ADDR_WIDTH:0] wr_off;
  logic [ADDR_WIDTH:0] rd_off;
  logic                wr_in;
  logic                rd_in;
  logic                wr_hit;
  logic                rd_hit;
  logic                wr_miss;
  logic                rd_miss;
  logic [IW-1:0]       wr_idx;
  logic [IW-1:0]       rd_idx;
  logic                apply;
  logic                wr_seen;

  // Addresses below base wrap to a huge offset, so one compare covers both ends.
  assign wr_off  = {1'b0, dcr_wr_addr} - {1'b0, BASE_ADDR};
  assign rd_off  = {1'b0, dcr_rd_addr} - {1'b0, BASE_ADDR};
  assign wr_in   = wr_off < LIMIT;
  assign rd_in   = rd_off < LIMIT;
  assign wr_idx  = wr_off[IW-1:0];
  assign rd_idx  = rd_off[IW-1:0];
  assign wr_hit  = dcr_wr_valid && wr_in;
  assign rd_hit  = dcr_rd_valid && rd_in;
  assign wr_miss = dcr_wr_valid && !wr_in;
  assign rd_miss = dcr_rd_valid && !rd_in;

  vx_dcr_bank_commit_ctrl u_commit_ctrl (
    .clk         (clk),
    .reset       (reset),
    .commit      (commit),
    .busy        (busy),
    .apply       (apply),
    .commit_done (commit_done)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow[i] <= RESET_VALUE;
        active[i] <= RESET_VALUE;
      end
    end else begin
      if (wr_hit) begin
        shadow[wr_idx] <= dcr_wr_data;
      end
      if (apply) begin
        active <= shadow;
      end
    end
  end

  // Dirty trails the write by a cycle; a write landing in APPLY re-arms it.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_seen          <= 1'b0;
      dirty            <= 1'b0;
      dcr_rd_rsp_valid <= 1'b0;
      dcr_rd_rsp_data  <= '0;
      addr_err         <= 1'b0;
    end else begin
      wr_seen          <= wr_hit;
      dcr_rd_rsp_valid <= dcr_rd_valid;
      dcr_rd_rsp_data  <= rd_hit ? shadow[rd_idx] : '0;
      addr_err         <= wr_miss || rd_miss;
      if (apply) begin
        dirty <= 1'b0;
      end else if (wr_seen) begin
        dirty <= 1'b1;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_active
    assign active_dcrs[g*DATA_WIDTH +: DATA_WIDTH] = active[g];
  end

endmodule

// File: tb/tb_vx_dcr_bank.sv
// Self-checking bench for vx_dcr_bank: read scoreboard plus
// directed commit, busy, range and reset sequences.
module tb_vx_dcr_bank;

  logic         clk = 1'b0;
  logic         reset;
  logic         dcr_wr_valid;
  logic [11:0]  dcr_wr_addr;
  logic [31:0]  dcr_wr_data;
  logic         dcr_rd_valid;
  logic [11:0]  dcr_rd_addr;
  logic         dcr_rd_rsp_valid;
  logic [31:0]  dcr_rd_rsp_data;
  logic         commit;
  logic         busy;
  logic         commit_done;
  logic         dirty;
  logic         addr_err;
  logic [127:0] active_dcrs;

  int checks = 0;
  int errors = 0;
  int err_seen = 0;
  int err_exp = 0;
  int done_seen = 0;
  int done_base;
  logic [31:0] q_rd [$];
  logic [31:0] model [4];

  vx_dcr_bank dut (
    .clk              (clk),
    .reset            (reset),
    .dcr_wr_valid     (dcr_wr_valid),
    .dcr_wr_addr      (dcr_wr_addr),
    .dcr_wr_data      (dcr_wr_data),
    .dcr_rd_valid     (dcr_rd_valid),
    .dcr_rd_addr      (dcr_rd_addr),
    .dcr_rd_rsp_valid (dcr_rd_rsp_valid),
    .dcr_rd_rsp_data  (dcr_rd_rsp_data),
    .commit           (commit),
    .busy             (busy),
    .commit_done      (commit_done),
    .dirty            (dirty),
    .addr_err         (addr_err),
    .active_dcrs      (active_dcrs)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] act(input int i);
    return active_dcrs[i*32 +: 32];
  endfunction

  function automatic logic in_rng(input logic [11:0] a);
    return (a >= 12'h001) && (a <= 12'h004);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic xfer(input logic w, input logic [11:0] wa,
                      input logic [31:0] wd, input logic r,
                      input logic [11:0] ra);
    dcr_wr_valid = w;
    dcr_wr_addr  = wa;
    dcr_wr_data  = wd;
    dcr_rd_valid = r;
    dcr_rd_addr  = ra;
    if (r) q_rd.push_back(in_rng(ra) ? model[ra-1] : 32'h0);
    if (w && in_rng(wa)) model[wa-1] = wd;
    if ((w && !in_rng(wa)) || (r && !in_rng(ra))) err_exp++;
    tick();
    dcr_wr_valid = 1'b0;
    dcr_rd_valid = 1'b0;
  endtask

  always @(negedge clk) begin
    if (dcr_rd_rsp_valid === 1'b1) begin
      if (q_rd.size() == 0) check("rd_extra", 32'(dcr_rd_rsp_valid), 32'h0);
      else check("rd_data", dcr_rd_rsp_data, q_rd.pop_front());
    end
    if (addr_err === 1'b1) err_seen++;
    if (commit_done === 1'b1) done_seen++;
  end

  initial begin
    reset = 1'b1;
    dcr_wr_valid = 1'b0;
    dcr_wr_addr = '0;
    dcr_wr_data = '0;
    dcr_rd_valid = 1'b0;
    dcr_rd_addr = '0;
    commit = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    tick(); tick(); tick();
    reset = 1'b0;
    check("rst_rsp_valid", 32'(dcr_rd_rsp_valid), 32'h0);
    check("rst_rsp_data", dcr_rd_rsp_data, 32'h0);
    check("rst_done", 32'(commit_done), 32'h0);
    check("rst_err", 32'(addr_err), 32'h0);
    check("rst_dirty", 32'(dirty), 32'h0);
    for (int i = 0; i < 4; i++) check("rst_active", act(i), 32'h0);

    for (int a = 1; a <= 4; a++) xfer(1'b0, '0, '0, 1'b1, 12'(a));
    tick(); tick();
    check("rst_err_cnt", 32'(err_seen), 32'h0);

    xfer(1'b1, 12'h002, 32'hDEADBEEF, 1'b0, '0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("c1_hold", act(1), 32'h0);
    check("c1_dirty_set", 32'(dirty), 32'h1);
    check("c1_done_early", 32'(commit_done), 32'h0);
    tick();
    check("c1_active", act(1), 32'hDEADBEEF);
    check("c1_done", 32'(commit_done), 32'h1);
    check("c1_dirty_clr", 32'(dirty), 32'h0);
    tick();
    check("c1_done_pulse", 32'(commit_done), 32'h0);

    done_base = done_seen;
    xfer(1'b1, 12'h003, 32'h55, 1'b0, '0);
    commit = 1'b1;
    busy = 1'b1;
    tick();
    commit = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i % 3 == 0) commit = 1'b1;
      tick();
      commit = 1'b0;
      check("busy_hold", act(2), 32'h0);
    end
    busy = 1'b0;
    tick();
    check("wait_apply", act(2), 32'h0);
    tick();
    check("wait_active", act(2), 32'h55);
    check("wait_done", 32'(commit_done), 32'h1);
    tick(); tick(); tick();
    check("wait_done_cnt", 32'(done_seen - done_base), 32'h1);

    xfer(1'b1, 12'h000, 32'hBAD, 1'b0, '0);
    xfer(1'b0, '0, '0, 1'b1, 12'h005);
    xfer(1'b1, 12'h000, 32'hBAD, 1'b1, 12'h005);
    tick(); tick();
    check("miss_err_cnt", 32'(err_seen), 32'(err_exp));
    for (int a = 1; a <= 4; a++) xfer(1'b0, '0, '0, 1'b1, 12'(a));

    xfer(1'b1, 12'h001, 32'h11, 1'b0, '0);
    xfer(1'b1, 12'h001, 32'h22, 1'b1, 12'h001);
    xfer(1'b0, '0, '0, 1'b1, 12'h001);
    tick();

    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    check("sync_done", 32'(commit_done), 32'h1);
    check("sync_active", act(0), 32'h22);
    tick();
    check("sync_dirty", 32'(dirty), 32'h0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    check("clean_done", 32'(commit_done), 32'h1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    check("b2b_done", 32'(commit_done), 32'h1);
    tick();

    commit = 1'b1;
    tick();
    commit = 1'b0;
    xfer(1'b1, 12'h004, 32'h77, 1'b0, '0);
    check("apw_active", act(3), 32'h0);
    check("apw_done", 32'(commit_done), 32'h1);
    tick();
    check("apw_dirty", 32'(dirty), 32'h1);
    check("apw_hold", act(3), 32'h0);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    check("apw_active2", act(3), 32'h77);
    check("apw_dirty2", 32'(dirty), 32'h0);
    tick();

    xfer(1'b1, 12'h002, 32'h99, 1'b0, '0);
    busy = 1'b1;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick(); tick();
    done_base = done_seen;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 32'h0;
    busy = 1'b0;
    tick(); tick(); tick();
    for (int i = 0; i < 4; i++) check("rstw_active", act(i), 32'h0);
    check("rstw_dirty", 32'(dirty), 32'h0);
    check("rstw_done_cnt", 32'(done_seen - done_base), 32'h0);
    xfer(1'b0, '0, '0, 1'b1, 12'h002);
    tick(); tick();

    check("err_cnt", 32'(err_seen), 32'(err_exp));
    check("rd_pending", 32'(q_rd.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vx_dcr_bank.md
Name: VX_dcr_bank

Overview:
Parametrised, double-buffered device-configuration register bank; the successor to the fixed base-DCR decoder.
- Host DCR writes land in a shadow array.
- A commit request copies shadow to the active array only once the consumer (core/cluster) is not busy, so in-flight kernels never see torn configuration.
- Adds readback, address-range error reporting, dirty tracking and commit completion signalling.
- Sits between the DCR bus fan-out and per-core configuration consumers.

Parameters:
NUM_REGS, 4, number of consecutive DCR registers in the bank (≥1)
DATA_WIDTH, 32, width of each register and of the DCR data bus
ADDR_WIDTH, 12, DCR address width
BASE_ADDR, 12'h001, DCR address of register index 0
RESET_VALUE, 0, value (DATA_WIDTH bits) loaded into every shadow and active register on reset

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
dcr_wr_valid  in  1  write strobe
dcr_wr_addr  in  ADDR_WIDTH  write address
dcr_wr_data  in  DATA_WIDTH  write data
dcr_rd_valid  in  1  read request strobe
dcr_rd_addr  in  ADDR_WIDTH  read address
dcr_rd_rsp_valid  out  1  read response valid
dcr_rd_rsp_data  out  DATA_WIDTH  read response data (shadow contents)
commit  in  1  request shadow-to-active transfer
busy  in  1  consumer busy; blocks the transfer
commit_done  out  1  one-cycle pulse, new active values visible
dirty  out  1  shadow differs from active by at least one uncommitted write
addr_err  out  1  one-cycle pulse, out-of-range access
active_dcrs  out  NUM_REGS*DATA_WIDTH  active registers; index i at bits [i*DATA_WIDTH +: DATA_WIDTH]

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values: shadow and active arrays = RESET_VALUE; FSM = IDLE; dirty = 0; dcr_rd_rsp_valid = 0; dcr_rd_rsp_data = 0; commit_done = 0; addr_err = 0.
- Reset mid-WAIT or mid-APPLY: the commit is abandoned and active returns to RESET_VALUE.
- Address decode: hit when BASE_ADDR ≤ addr < BASE_ADDR+NUM_REGS; idx = addr − BASE_ADDR, truncated to $clog2(NUM_REGS) bits (min 1). No wrap-around: addresses beyond the top are misses.
- Write hit: shadow[idx] is updated at the clock edge and dirty is set at the next edge.
- Write miss: shadow unchanged; addr_err pulses high the next cycle.
- Read: fixed 1-cycle latency. dcr_rd_rsp_valid and dcr_rd_rsp_data are registered.
  - Hit returns shadow[idx].
  - Miss returns 0 with rsp_valid = 1 and an addr_err pulse.
- Read and write to the same idx in the same cycle: the response carries the old value (read-before-write).
- A write miss and a read miss in the same cycle produce a single addr_err pulse.
- Commit FSM, states IDLE, WAIT, APPLY:
  - IDLE: commit && !busy → APPLY; commit && busy → WAIT.
  - WAIT: !busy → APPLY; otherwise stay.
  - APPLY: at the edge ending the cycle, active ← shadow as it stood at the start of the cycle; → IDLE. commit_done is high in the following cycle, coincident with the new active_dcrs.
  - commit asserted in WAIT or APPLY is coalesced, not queued.
  - commit in the same cycle that commit_done is high (FSM in IDLE) starts a new commit.
- Latency: commit sampled at cycle T with busy=0 → APPLY at T+1 → active and commit_done at T+2.
- Dirty:
  - Cleared at the APPLY edge.
  - A write hit in the APPLY cycle updates shadow only (not active) and leaves dirty = 1.
  - Commit with dirty = 0 still runs and pulses commit_done.
- busy toggling in WAIT: the transfer happens on the first cycle busy is sampled 0.

Decomposition:
- Shared package (VX_gpu_types or the DCR defines header):
  - DCR address constants for the bank base and its size
  - dcr_commit_state_e enum {IDLE, WAIT, APPLY}
  - Index-width helper macro
- Sub-module VX_dcr_commit_ctrl holds the FSM: inputs commit and busy; outputs apply and commit_done.
- The address decode and the shadow/active arrays stay in VX_dcr_bank.

Test Plan:
- Reset then read addr 0x001..0x004 → four responses 1 cycle later, each data=0; active_dcrs=0; dirty=0; addr_err never asserted.
- Write 0x002=0xDEADBEEF, commit with busy=0 at T → active idx1 stays 0 through T+1, =0xDEADBEEF and commit_done=1 at T+2; dirty 1 → 0.
- Write 0x003=0x55, commit while busy=1 for 10 cycles, then busy=0 → no change while busy; active idx2=0x55 two cycles after busy falls; one commit_done; extra commits during WAIT produce no second pulse.
- Write 0x000 and read 0x005 → addr_err pulses once for each; read returns valid with data 0; shadow unchanged.
- Same-cycle read and write of 0x001 (old 0x11, new 0x22) → response 0x11; next-cycle read → 0x22.
- Write in the APPLY cycle → active keeps the pre-write value, dirty=1; a second commit transfers the write. Separately, reset asserted in WAIT → state IDLE, active=RESET_VALUE, no commit_done.
